// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, frame geometry and the
// even-parity helper also used by the channel transmitter.
package uart_pkg;

  localparam int FRAME_BITS = 11;
  localparam int DATA_BITS  = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    BREAK  = 3'd5
  } state_e;

  function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
    return ^d;
  endfunction

  // Reorders a byte so d0 comes first, matching on-wire order in the raw frame.
  function automatic logic [DATA_BITS-1:0] wire_order(input logic [DATA_BITS-1:0] d);
    logic [DATA_BITS-1:0] r;
    for (int i = 0; i < DATA_BITS; i++) r[DATA_BITS-1-i] = d[i];
    return r;
  endfunction

endpackage

// File: rtl/uart_rx_frame_if.sv
// Receiver-side bundle: serial line in, decoded frame and status out.
// Handshake: data_valid is a one-cycle strobe with no ready; the frame fields
// (data_out, Packet_Out, parity_err, framing_err) are meaningful in that cycle.
interface uart_rx_frame_if;
  import uart_pkg::*;

  logic                  RX_Serial;
  logic [DATA_BITS-1:0]  data_out;
  logic [FRAME_BITS-1:0] Packet_Out;
  logic                  data_valid;
  logic                  parity_err;
  logic                  framing_err;
  logic                  rx_busy;

  modport master (
    input  RX_Serial,
    output data_out, Packet_Out, data_valid, parity_err, framing_err, rx_busy
  );

  modport slave (
    output RX_Serial,
    input  data_out, Packet_Out, data_valid, parity_err, framing_err, rx_busy
  );
endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line; flops reset to the
// idle (high) level so reset never looks like a start bit.
module uart_rx_sync (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);
  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;
endmodule

// File: rtl/uart_rx_frame.sv
// 11-bit UART frame receiver (start, 8 data LSB-first, even parity, stop).
// Define UART_RX_SYNC_EN to insert a 2-flop synchronizer on RX_Serial (+2 cycles).
module uart_rx_frame
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 1
) (
  input  logic             UART_CLK,
  input  logic             UART_RST_N,
  uart_rx_frame_if.master  rx_if,
  output state_e           dbg_state_o
);

  localparam int CW = 10;
  localparam int H  = (CLKS_PER_BIT - 1) / 2;
  localparam logic [CW-1:0] CNT_BIT  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = (H == 0) ? '0 : CW'(H - 1);

  logic rx_s;

`ifdef UART_RX_SYNC_EN
  uart_rx_sync u_sync (
    .clk_i  (UART_CLK),
    .rst_ni (UART_RST_N),
    .d_i    (rx_if.RX_Serial),
    .q_o    (rx_s)
  );
`else
  assign rx_s = rx_if.RX_Serial;
`endif

  state_e                state_q;
  logic [CW-1:0]         cnt_q;
  logic [2:0]            bit_idx_q;
  logic [DATA_BITS-1:0]  shift_q;
  logic                  parity_q;
  logic [DATA_BITS-1:0]  data_q;
  logic [FRAME_BITS-1:0] packet_q;
  logic                  valid_q;
  logic                  perr_q;
  logic                  ferr_q;

  always_ff @(posedge UART_CLK or negedge UART_RST_N) begin
    if (!UART_RST_N) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      parity_q  <= 1'b0;
      data_q    <= '0;
      packet_q  <= '0;
      valid_q   <= 1'b0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (!rx_s) begin
            bit_idx_q <= '0;
            // With one or two clocks per bit there is no mid-bit to re-check.
            if (H == 0) begin
              state_q <= DATA;
              cnt_q   <= CNT_BIT;
            end else begin
              state_q <= START;
              cnt_q   <= CNT_HALF;
            end
          end
        end
        START: begin
          if (cnt_q == '0) begin
            if (!rx_s) begin
              state_q   <= DATA;
              cnt_q     <= CNT_BIT;
              bit_idx_q <= '0;
            end else begin
              state_q <= IDLE;
            end
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        DATA: begin
          if (cnt_q == '0) begin
            shift_q   <= {rx_s, shift_q[DATA_BITS-1:1]};
            bit_idx_q <= bit_idx_q + 3'd1;
            cnt_q     <= CNT_BIT;
            if (bit_idx_q == 3'd7) state_q <= PARITY;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        PARITY: begin
          if (cnt_q == '0) begin
            parity_q <= rx_s;
            cnt_q    <= CNT_BIT;
            state_q  <= STOP;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        STOP: begin
          if (cnt_q == '0) begin
            data_q   <= shift_q;
            packet_q <= {1'b0, wire_order(shift_q), parity_q, rx_s};
            perr_q   <= even_parity(shift_q) ^ parity_q;
            ferr_q   <= ~rx_s;
            valid_q  <= 1'b1;
            cnt_q    <= '0;
            // A low stop bit means the line may be held in break; wait it out.
            state_q  <= rx_s ? IDLE : BREAK;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        BREAK: begin
          if (rx_s) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rx_if.data_out    = data_q;
  assign rx_if.Packet_Out  = packet_q;
  assign rx_if.data_valid  = valid_q;
  assign rx_if.parity_err  = perr_q;
  assign rx_if.framing_err = ferr_q;
  assign rx_if.rx_busy     = (state_q != IDLE);
  assign dbg_state_o       = state_q;

endmodule
